// File: rtl/player_motion_ctrl.sv
// Per-frame sprite motion controller: walk, jump and fall physics plus walk-cycle
// animation indexing, advanced once per rising frame_tick outside freeze.
`timescale 1ns/1ps
module player_motion_ctrl #(
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 440,
  parameter int X_MAX    = 610,
  parameter int FLOOR_Y  = 440,
  parameter int STEP     = 5,
  parameter int JUMP_V   = 12,
  parameter int MAX_FALL = 8,
  parameter int ANIM_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic [7:0] buttons,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing_right,
  output logic [9:0] anim_row,
  output logic [9:0] anim_col,
  output logic       grounded
);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, JUMP = 2'd2, FALL = 2'd3} state_t;

  localparam logic [9:0]         X_INIT_V  = 10'(X_INIT);
  localparam logic [9:0]         Y_INIT_V  = 10'(Y_INIT);
  localparam logic [9:0]         X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]         FLOOR_V   = 10'(FLOOR_Y);
  localparam logic signed [11:0] FLOOR_S   = 12'(FLOOR_Y);
  localparam logic [10:0]        STEP_W    = 11'(STEP);
  localparam logic [9:0]         STEP_N    = 10'(STEP);
  localparam logic signed [5:0]  JUMP_S    = 6'(JUMP_V);
  localparam logic signed [5:0]  MAX_S     = 6'(MAX_FALL);
  localparam logic [7:0]         ANIM_LAST = 8'(ANIM_DIV - 1);

  state_t              state;
  logic signed [5:0]   vy;
  logic [2:0]          anim_idx;
  logic [7:0]          anim_cnt;
  logic                tick_p0;

  logic                upd;
  logic                h_pos, h_neg, h_any, up;
  logic [9:0]          x_next;
  logic signed [11:0]  y_sum;
  logic signed [5:0]   vy_next;
  logic                unused_btn;

  function automatic logic [9:0] step_right(input logic [9:0] x);
    logic [10:0] s;
    s = {1'b0, x} + STEP_W;
    return (s > {1'b0, X_MAX_V}) ? X_MAX_V : s[9:0];
  endfunction

  function automatic logic [9:0] step_left(input logic [9:0] x);
    return (x < STEP_N) ? 10'd0 : x - STEP_N;
  endfunction

  function automatic logic signed [5:0] fall_clamp(input logic signed [5:0] v);
    logic signed [5:0] n;
    n = v + 6'sd1;
    return (n > MAX_S) ? MAX_S : n;
  endfunction

  function automatic logic [9:0] row_of(input logic [2:0] idx);
    return (idx >= 3'd3) ? 10'd30 : 10'd0;
  endfunction

  function automatic logic [9:0] col_of(input logic [2:0] idx);
    case (idx)
      3'd1, 3'd4: return 10'd23;
      3'd2, 3'd5: return 10'd46;
      default:    return 10'd0;
    endcase
  endfunction

  assign unused_btn = ^{buttons[7:4], buttons[2]};

  always_comb begin
    h_pos   = ~buttons[0] & buttons[1];
    h_neg   = ~buttons[1] & buttons[0];
    h_any   = h_pos | h_neg;
    up      = ~buttons[3];
    upd     = frame_tick & ~tick_p0 & ~freeze;
    x_next  = pos_x;
    if (h_pos)
      x_next = step_right(pos_x);
    else if (h_neg)
      x_next = step_left(pos_x);
    y_sum   = $signed({2'b00, pos_y}) + 12'(vy);
    vy_next = fall_clamp(vy);
  end

  assign anim_row = row_of(anim_idx);
  assign anim_col = col_of(anim_idx);

  // tick_p0: previous frame_tick sample; an update fires only on its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x        <= X_INIT_V;
      pos_y        <= Y_INIT_V;
      vy           <= 6'sd0;
      state        <= IDLE;
      facing_right <= 1'b1;
      anim_idx     <= 3'd0;
      anim_cnt     <= 8'd0;
      grounded     <= 1'b1;
      tick_p0      <= 1'b1;
    end else begin
      tick_p0 <= frame_tick;
      if (upd) begin
        pos_x <= x_next;
        if (h_pos)
          facing_right <= 1'b1;
        else if (h_neg)
          facing_right <= 1'b0;

        case (state)
          IDLE, WALK: begin
            if (up) begin
              state    <= JUMP;
              vy       <= -JUMP_S;
              anim_idx <= 3'd3;
              anim_cnt <= 8'd0;
              grounded <= 1'b0;
            end else if (h_any) begin
              state    <= WALK;
              grounded <= 1'b1;
              if (state != WALK) begin
                anim_idx <= 3'd0;
                anim_cnt <= 8'd0;
              end else if (anim_cnt == ANIM_LAST) begin
                anim_cnt <= 8'd0;
                anim_idx <= (anim_idx == 3'd5) ? 3'd0 : anim_idx + 3'd1;
              end else begin
                anim_cnt <= anim_cnt + 8'd1;
              end
            end else begin
              state    <= IDLE;
              grounded <= 1'b1;
              anim_idx <= 3'd0;
              anim_cnt <= 8'd0;
            end
          end

          JUMP: begin
            anim_idx <= 3'd3;
            anim_cnt <= 8'd0;
            grounded <= 1'b0;
            if (y_sum < 12'sd0) begin
              // Hitting the top edge kills upward speed and starts the fall
              pos_y <= 10'd0;
              vy    <= 6'sd0;
              state <= FALL;
            end else begin
              pos_y <= y_sum[9:0];
              vy    <= vy_next;
              if (vy_next >= 6'sd0)
                state <= FALL;
            end
          end

          FALL: begin
            if (y_sum >= FLOOR_S) begin
              pos_y    <= FLOOR_V;
              vy       <= 6'sd0;
              state    <= h_any ? WALK : IDLE;
              grounded <= 1'b1;
              anim_idx <= 3'd0;
              anim_cnt <= 8'd0;
            end else begin
              pos_y    <= y_sum[9:0];
              vy       <= vy_next;
              grounded <= 1'b0;
              anim_idx <= 3'd3;
              anim_cnt <= 8'd0;
            end
          end

          default: begin
            state    <= IDLE;
            vy       <= 6'sd0;
            grounded <= 1'b1;
            anim_idx <= 3'd0;
            anim_cnt <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule
